pwm_main: RTL and testbench
===========================

PWM_MAIN -- requirements
Module: pwm_main

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 4, width of the PWM period counter (period = 2^CNT_WIDTH clocks).
REQ-002 SHALL have parameter STEP_WIDTH, default 12, width of the ramp step timer (one duty increment per 2^STEP_WIDTH clocks).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port PWM_out, output, 1, registered PWM waveform with ramping duty cycle.
REQ-006 SHALL contain instance counter_inst holding 4-bit register counter, and instance stepper_inst holding 12-bit register step, with these hierarchical names, so a bench can preload both registers.
REQ-007 SHALL expose internal signals duty_cycle (5-bit) and stepper_counter (5-bit) at top level for waveform dumping.

Function
REQ-008 counter SHALL increment by 1 every clock and wrap 15 -> 0, giving a 16-clock PWM period.
REQ-009 step SHALL increment by 1 every clock and wrap 4095 -> 0.
REQ-010 On a clock edge where step == 4095, stepper_counter SHALL increment by 1, saturating at 16 with no wrap.
REQ-011 On a clock edge where counter == 15, duty_cycle SHALL load the pre-edge value of stepper_counter, so duty changes only at PWM period boundaries.
REQ-012 At every edge, PWM_out SHALL be set to 1 when counter < duty_cycle and to 0 otherwise, using pre-edge values (one-clock registered latency).
REQ-013 With duty_cycle == 0, PWM_out SHALL stay constant 0.
REQ-014 With duty_cycle == 16, PWM_out SHALL stay constant 1 (100 %).
REQ-015 With duty_cycle == N (1..15), PWM_out SHALL be high for exactly N consecutive clocks per 16-clock period.
REQ-016 After saturation, duty_cycle SHALL hold at 16 indefinitely; step and counter SHALL keep free-running.
REQ-017 Simultaneous step == 4095 and counter == 15 SHALL apply both updates, with duty_cycle taking the old stepper_counter value.

Reset
REQ-018 While rst_n is 0 at a rising edge, counter, step, stepper_counter, duty_cycle and PWM_out SHALL all become 0.
REQ-019 Reset SHALL take priority over all other updates, including mid-ramp; the ramp SHALL restart from duty 0 on the first clock with rst_n high.
REQ-020 No asynchronous behaviour: rst_n changes SHALL take effect only at the rising edge of clk.

Verification
REQ-021 Reset for 2 clocks, then release (release cycle = 0) -> PWM_out 0 through cycle 4112; stepper_counter = 1 from cycle 4096; duty_cycle = 1 from cycle 4112; first PWM_out high pulse at cycle 4113, 1 clock wide.
REQ-022 Run 100000 clocks from reset -> duty_cycle reaches 16 at cycle 65552; PWM_out constant 1 from cycle 65553 to end.
REQ-023 Sample any full period with duty_cycle = 8 -> exactly 8 high and 8 low clocks, with high first in the period.
REQ-024 Assert rst_n = 0 for 1 clock at cycle 30000 (mid-ramp) -> all registers 0 on the next edge; ramp restarts; duty_cycle = 1 again 4112 cycles after release.
REQ-025 Without rst_n, preload counter_inst.counter = 0 and stepper_inst.step = 0 at time 0 -> same ramp timing as REQ-021, with duty_cycle and stepper_counter reset-free behaviour not relied upon.
REQ-026 Check stepper_counter saturation -> the value stays 16 after cycle 65536 and never wraps to 0.

Source files
------------

// File: rtl/pwm_main.sv
// pwm_main -- PWM generator whose duty cycle ramps from 0 % to 100 %.
//
// A free-running period counter sets the PWM period (2^CNT_WIDTH clocks).
// A free-running step timer advances the ramp level (stepper_counter) once
// per 2^STEP_WIDTH clocks. The ramp level saturates at 2^CNT_WIDTH, which is
// full on. duty_cycle only takes a new ramp level at the end of a PWM
// period, so every period is produced with a single, consistent duty value.
//
// Ports:
//   clk     in   single clock, all state changes on its rising edge
//   rst_n   in   synchronous, active-low reset
//   PWM_out out  registered PWM waveform (one clock behind the compare)
//
// Internal signals duty_cycle and stepper_counter are kept at top level so
// they are visible in waveforms.

// Period counter: free-running, wraps at all-ones.
//   clk, rst_n : as top level
//   value      : current counter value
//   wrap       : high while the counter sits at its last value
module pwm_period_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);
  logic [WIDTH-1:0] counter;

  always_ff @(posedge clk) begin
    if (!rst_n) counter <= '0;
    else        counter <= counter + 1'b1;
  end

  assign value = counter;
  assign wrap  = (counter == {WIDTH{1'b1}});
endmodule

// Ramp step timer: free-running, wraps at all-ones.
//   clk, rst_n : as top level
//   wrap       : high while the timer sits at its last value
module pwm_step_timer #(
  parameter int WIDTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap
);
  logic [WIDTH-1:0] step;

  always_ff @(posedge clk) begin
    if (!rst_n) step <= '0;
    else        step <= step + 1'b1;
  end

  assign wrap = (step == {WIDTH{1'b1}});
endmodule

module pwm_main #(
  parameter int CNT_WIDTH  = 4,
  parameter int STEP_WIDTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  output logic PWM_out
);
  // Full-on level: one more than the largest counter value, hence the
  // extra bit on duty_cycle and stepper_counter.
  localparam logic [CNT_WIDTH:0] DUTY_MAX = {1'b1, {CNT_WIDTH{1'b0}}};

  logic [CNT_WIDTH-1:0] count;
  logic                 count_wrap;
  logic                 step_wrap;
  logic [CNT_WIDTH:0]   duty_cycle;
  logic [CNT_WIDTH:0]   stepper_counter;

  pwm_period_counter #(.WIDTH(CNT_WIDTH)) counter_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .value (count),
    .wrap  (count_wrap)
  );

  pwm_step_timer #(.WIDTH(STEP_WIDTH)) stepper_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .wrap  (step_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stepper_counter <= '0;
      duty_cycle      <= '0;
      PWM_out         <= 1'b0;
    end else begin
      // Ramp level saturates at full-on rather than wrapping back to 0.
      if (step_wrap && (stepper_counter != DUTY_MAX))
        stepper_counter <= stepper_counter + 1'b1;
      // Takes the pre-edge ramp level, even if it advances on this same edge.
      if (count_wrap)
        duty_cycle <= stepper_counter;
      // Zero-extended compare: duty 0 never fires, DUTY_MAX always fires.
      PWM_out <= ({1'b0, count} < duty_cycle);
    end
  end
endmodule

// File: tb/tb_pwm_main.sv
// tb_pwm_main -- directed check of pwm_main timing with default parameters.
// "cycle n" is the state seen n rising edges after reset release.
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s: observed=%0d expected=%0d", tag, (obs), (exp)); \
    end \
  end

module tb_pwm_main;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PWM_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int highs = 0;
  int sat_bad = 0;
  bit sat_watch = 1'b0;
  logic [15:0] hist = '0;

  pwm_main #(.CNT_WIDTH(4), .STEP_WIDTH(12)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PWM_out (PWM_out)
  );

  always #5 clk = ~clk;

  // Advance n edges, sampling 1 time unit after each edge. hist keeps the
  // last 16 PWM samples, newest in bit 0.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (PWM_out === 1'b1) highs++;
      hist = {hist[14:0], PWM_out};
      if (sat_watch && (dut.stepper_counter !== 5'd16)) sat_bad++;
    end
  endtask

  initial begin
    // Reset for 2 clocks.
    rst_n = 1'b0;
    run(2);
    `CHK("rst_pwm",     PWM_out, 1'b0)
    `CHK("rst_duty",    dut.duty_cycle, 5'd0)
    `CHK("rst_stepcnt", dut.stepper_counter, 5'd0)
    `CHK("rst_counter", dut.counter_inst.counter, 4'd0)
    `CHK("rst_step",    dut.stepper_inst.step, 12'd0)
    rst_n = 1'b1;
    cyc = 0; highs = 0;
    $display("reset released");

    run(4095);
    `CHK("stepcnt_c4095", dut.stepper_counter, 5'd0)
    run(1);
    `CHK("stepcnt_c4096", dut.stepper_counter, 5'd1)
    run(15);
    `CHK("duty_c4111", dut.duty_cycle, 5'd0)
    run(1);
    `CHK("duty_c4112", dut.duty_cycle, 5'd1)
    `CHK("pwm_c4112", PWM_out, 1'b0)
    `CHK("highs_duty0", highs, 0)
    run(1);
    `CHK("pwm_c4113", PWM_out, 1'b1)
    run(1);
    `CHK("pwm_c4114", PWM_out, 1'b0)
    $display("first pulse at cycle 4113 checked");

    // Mid-ramp reset for one clock: duty=1, stepper=1, counters non-zero.
    run(86);
    rst_n = 1'b0;
    run(1);
    `CHK("mid_pwm",     PWM_out, 1'b0)
    `CHK("mid_duty",    dut.duty_cycle, 5'd0)
    `CHK("mid_stepcnt", dut.stepper_counter, 5'd0)
    `CHK("mid_counter", dut.counter_inst.counter, 4'd0)
    `CHK("mid_step",    dut.stepper_inst.step, 12'd0)
    rst_n = 1'b1;
    cyc = 0; highs = 0;
    $display("mid-ramp reset released");

    run(4111);
    `CHK("rr_duty_c4111", dut.duty_cycle, 5'd0)
    run(1);
    `CHK("rr_duty_c4112", dut.duty_cycle, 5'd1)
    `CHK("rr_highs", highs, 0)

    // Duty 3 period: PWM cycles 12305..12320, high first.
    run(12320 - 4112);
    `CHK("duty3_val", dut.duty_cycle, 5'd3)
    `CHK("duty3_pat", hist, 16'hE000)
    $display("duty 3 period checked at cycle %0d", cyc);

    // Duty 8 period: PWM cycles 32785..32800, 8 high then 8 low.
    run(32800 - 12320);
    `CHK("duty8_val", dut.duty_cycle, 5'd8)
    `CHK("duty8_pat", hist, 16'hFF00)
    $display("duty 8 period checked at cycle %0d", cyc);

    // Saturation.
    run(65535 - 32800);
    `CHK("stepcnt_c65535", dut.stepper_counter, 5'd15)
    run(1);
    `CHK("stepcnt_c65536", dut.stepper_counter, 5'd16)
    sat_watch = 1'b1;
    run(15);
    `CHK("duty_c65551", dut.duty_cycle, 5'd15)
    run(1);
    `CHK("duty_c65552", dut.duty_cycle, 5'd16)
    `CHK("pwm_c65552", PWM_out, 1'b0)
    highs = 0;
    // Past cycle 69632, where the step timer wraps again with stepper at 16.
    run(69700 - 65552);
    `CHK("full_on_highs", highs, 69700 - 65552)
    `CHK("sat_never_left", sat_bad, 0)
    `CHK("sat_duty_end", dut.duty_cycle, 5'd16)
    `CHK("free_counter", dut.counter_inst.counter, 4'd4)
    `CHK("free_step", dut.stepper_inst.step, 12'd68)
    $display("saturation checked through cycle %0d", cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
